// File: rtl/ConvPkg.sv
// rtl/ConvPkg.sv - shared constants and FSM state type for the convolution front end
package ConvPkg;

  localparam int DataWidth  = 32;
  localparam int KSide      = 3;
  localparam int KernelSize = KSide * KSide;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/line_delay.sv
// rtl/line_delay.sv - enabled shift-register delay of Depth words
module line_delay #(
  parameter int DataWidth = 32,
  parameter int Depth     = 28
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [DataWidth-1:0] din,
  output logic [DataWidth-1:0] dout
);

  // Contents are never cleared; the window gating upstream keeps stale words out.
  logic [DataWidth-1:0] taps [Depth];

  always_ff @(posedge clk) begin
    if (en) begin
      taps[0] <= din;
      for (int i = 1; i < Depth; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[Depth-1];

endmodule

// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - per-channel 3x3 sliding window generator over a raster pixel stream
module line_window_buffer #(
  parameter int DataWidth   = 32,
  parameter int InputDim    = 4,
  parameter int ImageWidth  = 28,
  parameter int ImageHeight = 28
) (
  input  logic                                             Clk,
  input  logic                                             Rst,
  input  logic [InputDim*DataWidth-1:0]                    pixel_in,
  input  logic                                             pixel_valid,
  output logic [InputDim*ConvPkg::KernelSize*DataWidth-1:0] window_out,
  output logic                                             window_valid,
  output logic                                             frame_done
);

  import ConvPkg::fsm_state_e;
  import ConvPkg::FILL;
  import ConvPkg::RUN;

  localparam int KS   = ConvPkg::KSide;
  localparam int ColW = $clog2(ImageWidth);
  localparam int RowW = $clog2(ImageHeight);
  localparam logic [ColW-1:0] ColLast = ColW'(ImageWidth - 1);
  localparam logic [ColW-1:0] ColTwo  = ColW'(2);
  localparam logic [RowW-1:0] RowLast = RowW'(ImageHeight - 1);
  localparam logic [RowW-1:0] RowOne  = RowW'(1);

  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;
  fsm_state_e      state_q, state_d;
  logic            accept, last_col, frame_end, emit;

  assign accept    = pixel_valid;
  assign last_col  = (col_q == ColLast);
  assign frame_end = last_col && (row_q == RowLast);

  // Windows only exist once two full rows are buffered and two columns of this row are in.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    case (state_q)
      FILL: begin
        if (accept && last_col && (row_q == RowOne)) state_d = RUN;
      end
      RUN: begin
        emit = accept && (col_q >= ColTwo);
        if (accept && frame_end) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  logic [DataWidth-1:0] row_new [InputDim][KS];

  for (genvar ch = 0; ch < InputDim; ch++) begin : g_chan
    logic [DataWidth-1:0] d1, d2;

    line_delay #(.DataWidth(DataWidth), .Depth(ImageWidth)) u_ld0 (
      .clk  (Clk),
      .en   (accept),
      .din  (pixel_in[ch*DataWidth +: DataWidth]),
      .dout (d1)
    );

    line_delay #(.DataWidth(DataWidth), .Depth(ImageWidth)) u_ld1 (
      .clk  (Clk),
      .en   (accept),
      .din  (d1),
      .dout (d2)
    );

    assign row_new[ch][0] = d2;
    assign row_new[ch][1] = d1;
    assign row_new[ch][2] = pixel_in[ch*DataWidth +: DataWidth];
  end

  logic [DataWidth-1:0] win_q   [InputDim][KS][KS];
  logic [DataWidth-1:0] win_nxt [InputDim][KS][KS];
  logic [InputDim*KS*KS*DataWidth-1:0] win_nxt_flat;

  always_comb begin
    win_nxt_flat = '0;
    for (int ch = 0; ch < InputDim; ch++) begin
      for (int r = 0; r < KS; r++) begin
        for (int c = 0; c < KS - 1; c++) begin
          win_nxt[ch][r][c] = win_q[ch][r][c+1];
        end
        win_nxt[ch][r][KS-1] = row_new[ch][r];
        for (int c = 0; c < KS; c++) begin
          win_nxt_flat[((ch*KS + r)*KS + c)*DataWidth +: DataWidth] = win_nxt[ch][r][c];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) win_q <= win_nxt;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= FILL;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      window_out   <= '0;
    end else begin
      state_q      <= state_d;
      window_valid <= emit;
      frame_done   <= emit && frame_end;
      if (emit) window_out <= win_nxt_flat;
      if (accept) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// tb/tb_line_window_buffer.sv - directed self-checking bench for line_window_buffer on a 4x4 frame
module tb_line_window_buffer;

  localparam int DW = 32;
  localparam int ID = 4;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int WB = ID * 9 * DW;

  logic            Clk = 1'b0;
  logic            Rst = 1'b0;
  logic [ID*DW-1:0] pixel_in = '0;
  logic            pixel_valid = 1'b0;
  logic [WB-1:0]   window_out;
  logic            window_valid;
  logic            frame_done;

  line_window_buffer #(
    .DataWidth  (DW),
    .InputDim   (ID),
    .ImageWidth (IW),
    .ImageHeight(IH)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .window_out  (window_out),
    .window_valid(window_valid),
    .frame_done  (frame_done)
  );

  always #5 Clk = ~Clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   viol  = 0;
  int   acc22 = 0;
  logic pv_prev = 1'b0;

  logic [WB-1:0] wq [$];
  logic          fdq [$];
  int            cq [$];

  always @(posedge Clk) begin
    cyc     <= cyc + 1;
    pv_prev <= pixel_valid;
  end

  always @(negedge Clk) begin
    if (Rst && window_valid) begin
      wq.push_back(window_out);
      fdq.push_back(frame_done);
      cq.push_back(cyc);
      if (!pv_prev) viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int off, input int ch, input int r, input int c);
    return 32'(off + ch*100 + r*IW + c);
  endfunction

  task automatic drive(input int off, input int r, input int c);
    for (int ch = 0; ch < ID; ch++) pixel_in[ch*DW +: DW] = pix(off, ch, r, c);
    pixel_valid = 1'b1;
    @(posedge Clk);
    #1;
    pixel_valid = 1'b0;
    if (r == 2 && c == 2) acc22 = cyc;
    check($sformatf("wv_after_px_%0d_%0d", r, c), 64'(window_valid), 64'(r >= 2 && c >= 2));
    check($sformatf("fd_after_px_%0d_%0d", r, c), 64'(frame_done), 64'(r == IH-1 && c == IW-1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b0;
      @(posedge Clk);
      #1;
      check("wv_idle", 64'(window_valid), 64'(0));
    end
  endtask

  task automatic send_frame(input int off, input bit gaps, input int npix);
    for (int p = 0; p < npix; p++) begin
      if (gaps) begin
        int n = 0;
        while (($urandom % 2) == 1 && n < 3) begin
          idle(1);
          n++;
        end
      end
      drive(off, p / IW, p % IW);
    end
  endtask

  task automatic verify(input string name, input int n, input int off0, input int off1);
    check({name, "_count"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < wq.size() && i < n; i++) begin
      logic [WB-1:0] w;
      int off, wi, wr, wc;
      w   = wq[i];
      off = (i < 4) ? off0 : off1;
      wi  = i % 4;
      wr  = 2 + wi / 2;
      wc  = 2 + wi % 2;
      for (int ch = 0; ch < ID; ch++) begin
        for (int k = 0; k < 9; k++) begin
          check($sformatf("%s_w%0d_ch%0d_k%0d", name, i, ch, k),
                64'(w[(ch*9 + k)*DW +: DW]), 64'(pix(off, ch, wr - 2 + k/3, wc - 2 + k%3)));
        end
      end
      check($sformatf("%s_w%0d_fd", name, i), 64'(fdq[i]), 64'(wi == 3));
    end
    wq.delete();
    fdq.delete();
    cq.delete();
  endtask

  initial begin
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_wv", 64'(window_valid), 64'(0));
    check("rst_fd", 64'(frame_done), 64'(0));
    check("rst_wout", 64'(|window_out), 64'(0));
    Rst = 1'b1;
    idle(2);

    send_frame(0, 1'b0, IW*IH);
    idle(2);
    check("cont_first_latency", 64'((cq.size() > 0) ? cq[0] : -1), 64'(acc22));
    verify("cont", 4, 0, 0);

    send_frame(0, 1'b1, IW*IH);
    idle(2);
    verify("gaps", 4, 0, 0);

    send_frame(0, 1'b0, IW*IH);
    send_frame(1000, 1'b0, IW*IH);
    idle(2);
    verify("b2b", 8, 0, 1000);

    send_frame(0, 1'b0, 2*IW + 2);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check("midrst_wv", 64'(window_valid), 64'(0));
    check("midrst_fd", 64'(frame_done), 64'(0));
    check("midrst_wout", 64'(|window_out), 64'(0));
    Rst = 1'b1;
    check("midrst_nowin", 64'(wq.size()), 64'(0));
    send_frame(2000, 1'b0, IW*IH);
    idle(2);
    verify("after_rst", 4, 2000, 0);

    check("wv_after_idle_viol", 64'(viol), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
